// File: rtl/dm_mmio_if.sv
// Load/store bus from the CPU MEM stage to the data-memory subsystem.
// The master drives the access; the slave answers Dout in the same cycle.
interface dm_mmio_if;
    logic        mem_w;
    logic [2:0]  DMType;
    logic [31:0] Addr;
    logic [31:0] Din;
    logic [31:0] Dout;

    modport master (
        output mem_w,
        output DMType,
        output Addr,
        output Din,
        input  Dout
    );

    modport slave (
        input  mem_w,
        input  DMType,
        input  Addr,
        input  Din,
        output Dout
    );
endinterface

// File: rtl/dm_mmio.sv
// Data-memory subsystem: byte-lane RAM with sub-word loads/stores plus a small
// MMIO window (64-bit cycle counter, GPIO output, sticky access-error status).
// Optional macro DM_TIMER_EN adds a timer compare register at +0x10, widens the
// window to 32 bytes and drives irq from a W1C pending bit (status bit 2).
module dm_mmio #(
    parameter int unsigned DEPTH_WORDS = 128,
    parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    dm_mmio_if.slave    bus,
    output logic [15:0] gpio_out,
    output logic        err,
    output logic        irq
);
    localparam int unsigned IdxW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] RamBytes = 32'(DEPTH_WORDS * 4);
`ifdef DM_TIMER_EN
    localparam int unsigned WinLsb = 5;
`else
    localparam int unsigned WinLsb = 4;
`endif

    // State
    logic [31:0] mem [DEPTH_WORDS];
    logic [63:0] cnt_q;
    logic [15:0] gpio_q, gpio_d;
    logic [1:0]  status_q, status_d;
    logic        pend;
`ifdef DM_TIMER_EN
    logic [31:0] cmp_q, cmp_d;
    logic        pend_q, pend_d;
    logic        sel_cmp;
`endif

    // Decode
    logic            is_ram, is_mmio, is_word, is_half, is_byte, bad_type;
    logic            upper;
    logic            sel_lo, sel_hi, sel_gpio, sel_status, hole;
    logic            illegal, misalign, acc_ok, wr_en;
    logic [IdxW-1:0] idx;
    logic [31:0]     word, ram_rdata, mmio_rdata, wdata;
    logic [15:0]     half;
    logic [7:0]      lane8;
    logic [3:0]      be;

    assign idx     = bus.Addr[IdxW+1:2];
    assign is_ram  = (bus.Addr < RamBytes);
    assign is_mmio = (bus.Addr[31:WinLsb] == MMIO_BASE[31:WinLsb]);

`ifdef DM_TIMER_EN
    assign upper = bus.Addr[4];
    assign pend  = pend_q;
`else
    assign upper = 1'b0;
    assign pend  = 1'b0;
`endif

    // Access type and MMIO register select
    always_comb begin
        is_word    = (bus.DMType == 3'd0);
        is_half    = (bus.DMType == 3'd1) || (bus.DMType == 3'd2);
        is_byte    = (bus.DMType == 3'd3) || (bus.DMType == 3'd4);
        bad_type   = !(is_word || is_half || is_byte);
        sel_lo     = 1'b0;
        sel_hi     = 1'b0;
        sel_gpio   = 1'b0;
        sel_status = 1'b0;
        hole       = 1'b0;
`ifdef DM_TIMER_EN
        sel_cmp    = 1'b0;
`endif
        if (is_mmio) begin
            case ({upper, bus.Addr[3:2]})
                3'b000:  sel_lo     = 1'b1;
                3'b001:  sel_hi     = 1'b1;
                3'b010:  sel_gpio   = 1'b1;
                3'b011:  sel_status = 1'b1;
`ifdef DM_TIMER_EN
                3'b100:  sel_cmp    = 1'b1;
`endif
                default: hole       = 1'b1;
            endcase
        end
        // Illegal takes precedence over misaligned so one access sets one bit.
        illegal  = bad_type || !(is_ram || is_mmio) || (is_mmio && (!is_word || hole));
        misalign = !illegal && ((is_word && (bus.Addr[1:0] != 2'b00)) ||
                                (is_half && bus.Addr[0]));
        acc_ok   = !illegal && !misalign;
        wr_en    = bus.mem_w && acc_ok;
    end

    // RAM read with sub-word extraction and extension
    always_comb begin
        word = mem[idx];
        half = bus.Addr[1] ? word[31:16] : word[15:0];
        case (bus.Addr[1:0])
            2'd0:    lane8 = word[7:0];
            2'd1:    lane8 = word[15:8];
            2'd2:    lane8 = word[23:16];
            default: lane8 = word[31:24];
        endcase
        case (bus.DMType)
            3'd0:    ram_rdata = word;
            3'd1:    ram_rdata = {{16{half[15]}}, half};
            3'd2:    ram_rdata = {16'h0000, half};
            3'd3:    ram_rdata = {{24{lane8[7]}}, lane8};
            3'd4:    ram_rdata = {24'h000000, lane8};
            default: ram_rdata = '0;
        endcase
    end

    // MMIO read mux and final load data
    always_comb begin
        mmio_rdata = '0;
        if (sel_lo)     mmio_rdata = cnt_q[31:0];
        if (sel_hi)     mmio_rdata = cnt_q[63:32];
        if (sel_gpio)   mmio_rdata = {16'h0000, gpio_q};
        if (sel_status) mmio_rdata = {29'd0, pend, status_q};
`ifdef DM_TIMER_EN
        if (sel_cmp)    mmio_rdata = cmp_q;
`endif
        bus.Dout = acc_ok ? (is_ram ? ram_rdata : mmio_rdata) : 32'h0;
    end

    // Store lane enables; data is replicated so each lane sees its own bits
    always_comb begin
        be    = 4'h0;
        wdata = bus.Din;
        if (is_word) begin
            be = 4'hF;
        end else if (is_half) begin
            be    = bus.Addr[1] ? 4'hC : 4'h3;
            wdata = {2{bus.Din[15:0]}};
        end else if (is_byte) begin
            be    = 4'b0001 << bus.Addr[1:0];
            wdata = {4{bus.Din[7:0]}};
        end
    end

    // RAM array: cleared on reset, lane-masked write otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en && is_ram) begin
            for (int unsigned l = 0; l < 4; l++) begin
                if (be[l]) begin
                    mem[idx][l*8 +: 8] <= wdata[l*8 +: 8];
                end
            end
        end
    end

    // Next state for GPIO, status and timer; error set wins over W1C
    always_comb begin
        gpio_d   = gpio_q;
        status_d = status_q;
        if (wr_en && sel_gpio)   gpio_d   = bus.Din[15:0];
        if (wr_en && sel_status) status_d = status_q & ~bus.Din[1:0];
        if (bus.mem_w && misalign) status_d[0] = 1'b1;
        if (bus.mem_w && illegal)  status_d[1] = 1'b1;
`ifdef DM_TIMER_EN
        cmp_d  = cmp_q;
        pend_d = pend_q;
        if (wr_en && sel_status && bus.Din[2]) pend_d = 1'b0;
        if (wr_en && sel_cmp) begin
            cmp_d  = bus.Din;
            pend_d = 1'b0;
        end
        if ((cnt_q[31:0] == cmp_q) && (cmp_q != 32'h0)) pend_d = 1'b1;
`endif
    end

    // Register update
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            gpio_q   <= '0;
            status_q <= '0;
`ifdef DM_TIMER_EN
            cmp_q    <= '0;
            pend_q   <= 1'b0;
`endif
        end else begin
            cnt_q    <= cnt_q + 64'd1;
            gpio_q   <= gpio_d;
            status_q <= status_d;
`ifdef DM_TIMER_EN
            cmp_q    <= cmp_d;
            pend_q   <= pend_d;
`endif
        end
    end

    assign gpio_out = gpio_q;
    assign err      = |status_q;
    assign irq      = pend;
endmodule

// File: tb/tb_dm_mmio.sv
// Self-checking bench for dm_mmio: a table of single-cycle load/store vectors
// followed by hand-written sequences for errors, counter, GPIO and timer.
module tb_dm_mmio;
    localparam logic [31:0] MB = 32'h8000_0000;
    localparam logic [2:0]  W  = 3'd0;
    localparam logic [2:0]  H  = 3'd1;
    localparam logic [2:0]  HU = 3'd2;
    localparam logic [2:0]  B  = 3'd3;
    localparam logic [2:0]  BU = 3'd4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] gpio_out;
    logic        err;
    logic        irq;

    int checks = 0;
    int errors = 0;

    dm_mmio_if bus ();

    dm_mmio dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .gpio_out (gpio_out),
        .err      (err),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [2:0]  ty;
        logic [31:0] addr;
        logic [31:0] din;
        logic [31:0] exp;
        string       name;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;

    vec_t tbl[$];
    sb_t  sb_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] ex);
        checks++;
        if (act !== ex) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, ex);
        end
    endtask

    // One bus access: drive at negedge, check load data, let the edge commit.
    task automatic drive(input logic we, input logic [2:0] ty, input logic [31:0] addr,
                         input logic [31:0] din, input logic [31:0] ex, input string nm);
        sb_t e;
        @(negedge clk);
        bus.mem_w  = we;
        bus.DMType = ty;
        bus.Addr   = addr;
        bus.Din    = din;
        sb_q.push_back('{name: nm, exp: ex});
        #2;
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            chk(e.name, {32'h0, bus.Dout}, {32'h0, e.exp});
        end
        @(posedge clk);
        #1;
        bus.mem_w = 1'b0;
    endtask

    initial begin
        bus.mem_w  = 1'b0;
        bus.DMType = W;
        bus.Addr   = '0;
        bus.Din    = '0;

        tbl.push_back('{1'b1, W,  32'h10,  32'hDEADBEEF, 32'h00000000, "st_word_old"});
        tbl.push_back('{1'b0, W,  32'h10,  32'h0,        32'hDEADBEEF, "ld_word"});
        tbl.push_back('{1'b1, B,  32'h12,  32'h5A,       32'hFFFFFFAD, "st_byte_old"});
        tbl.push_back('{1'b0, W,  32'h10,  32'h0,        32'hDE5ABEEF, "ld_word_merged"});
        tbl.push_back('{1'b0, B,  32'h13,  32'h0,        32'hFFFFFFDE, "ld_byte_s"});
        tbl.push_back('{1'b0, BU, 32'h13,  32'h0,        32'h000000DE, "ld_byte_u"});
        tbl.push_back('{1'b0, H,  32'h12,  32'h0,        32'hFFFFDE5A, "ld_half_s"});
        tbl.push_back('{1'b0, HU, 32'h12,  32'h0,        32'h0000DE5A, "ld_half_u"});
        tbl.push_back('{1'b0, BU, 32'h10,  32'h0,        32'h000000EF, "ld_byte0_u"});
        tbl.push_back('{1'b0, B,  32'h11,  32'h0,        32'hFFFFFFBE, "ld_byte1_s"});
        tbl.push_back('{1'b0, H,  32'h10,  32'h0,        32'hFFFFBEEF, "ld_half0_s"});
        tbl.push_back('{1'b0, HU, 32'h10,  32'h0,        32'h0000BEEF, "ld_half0_u"});
        tbl.push_back('{1'b1, H,  32'h16,  32'h12348001, 32'h00000000, "st_half_old"});
        tbl.push_back('{1'b0, W,  32'h14,  32'h0,        32'h80010000, "ld_after_half"});
        tbl.push_back('{1'b0, H,  32'h16,  32'h0,        32'hFFFF8001, "ld_half_hi_s"});
        tbl.push_back('{1'b1, BU, 32'h15,  32'hFFFFFF77, 32'h00000000, "st_byte1_old"});
        tbl.push_back('{1'b0, W,  32'h14,  32'h0,        32'h80017700, "ld_after_byte1"});
        tbl.push_back('{1'b0, W,  32'h11,  32'h0,        32'h00000000, "ld_word_misal"});
        tbl.push_back('{1'b0, H,  32'h13,  32'h0,        32'h00000000, "ld_half_misal"});
        tbl.push_back('{1'b0, 3'd5, 32'h10, 32'h0,       32'h00000000, "ld_type5"});
        tbl.push_back('{1'b0, 3'd7, 32'h10, 32'h0,       32'h00000000, "ld_type7"});
        tbl.push_back('{1'b1, W,  32'h1FC, 32'hCAFEF00D, 32'h00000000, "st_top_old"});
        tbl.push_back('{1'b0, W,  32'h1FC, 32'h0,        32'hCAFEF00D, "ld_top"});
        tbl.push_back('{1'b0, W,  32'h200, 32'h0,        32'h00000000, "ld_past_ram"});
        tbl.push_back('{1'b0, W,  32'h40000000, 32'h0,   32'h00000000, "ld_unmapped"});
        tbl.push_back('{1'b0, W,  MB + 32'hC, 32'h0,     32'h00000000, "status_clean"});
        tbl.push_back('{1'b0, W,  MB + 32'h8, 32'h0,     32'h00000000, "gpio_reset"});
        tbl.push_back('{1'b0, W,  MB + 32'h4, 32'h0,     32'h00000000, "cnt_hi_small"});

        // Reset state
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #2;
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_irq", 64'(irq), 64'd0);
        chk("rst_gpio", 64'(gpio_out), 64'd0);
        chk("rst_dout_ram", {32'h0, bus.Dout}, 64'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].we, tbl[i].ty, tbl[i].addr, tbl[i].din, tbl[i].exp, tbl[i].name);
        end
        chk("err_after_table", 64'(err), 64'd0);

        // Misaligned store: suppressed, sticky bit0, cleared by W1C
        drive(1'b1, W, 32'h21, 32'h11111111, 32'h0, "misal_st_dout");
        chk("misal_err", 64'(err), 64'd1);
        drive(1'b0, W, 32'h20, 32'h0, 32'h0, "misal_ram_20");
        drive(1'b0, W, 32'h24, 32'h0, 32'h0, "misal_ram_24");
        drive(1'b0, W, MB + 32'hC, 32'h0, 32'h1, "misal_status");
        drive(1'b1, W, MB + 32'hC, 32'h1, 32'h1, "w1c_status_old");
        chk("w1c_err", 64'(err), 64'd0);
        drive(1'b0, W, MB + 32'hC, 32'h0, 32'h0, "w1c_status_new");

        // GPIO and illegal MMIO / unmapped stores
        drive(1'b1, W, MB + 32'h8, 32'h0001ABCD, 32'h0, "gpio_wr_old");
        chk("gpio_out", 64'(gpio_out), 64'hABCD);
        drive(1'b0, W, MB + 32'h8, 32'h0, 32'h0000ABCD, "gpio_rd");
        drive(1'b1, B, MB + 32'h8, 32'hFF, 32'h0, "gpio_byte_dout");
        chk("gpio_byte_kept", 64'(gpio_out), 64'hABCD);
        chk("gpio_byte_err", 64'(err), 64'd1);
        drive(1'b0, W, MB + 32'hC, 32'h0, 32'h2, "illegal_status");
        drive(1'b1, W, MB + 32'hC, 32'h2, 32'h2, "w1c_bit1");
        chk("w1c_bit1_err", 64'(err), 64'd0);
        drive(1'b1, W, 32'h40000000, 32'h5, 32'h0, "unmapped_st_dout");
        drive(1'b0, W, MB + 32'hC, 32'h0, 32'h2, "unmapped_status");
        drive(1'b1, W, MB + 32'hC, 32'h2, 32'h2, "w1c_bit1_b");
        drive(1'b1, W, MB + 32'h0, 32'h1234, dut_cnt_model(), "cnt_wr_ignored");
        drive(1'b0, W, MB + 32'hC, 32'h0, 32'h0, "cnt_wr_no_err");
`ifndef DM_TIMER_EN
        drive(1'b1, W, MB + 32'h10, 32'h7, 32'h0, "hole_st_dout");
        drive(1'b0, W, MB + 32'hC, 32'h0, 32'h2, "hole_status");
        drive(1'b1, W, MB + 32'hC, 32'h2, 32'h2, "w1c_hole");
`endif

        // Counter: 10 edges after reset, then wrap of the low half
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (9) @(negedge clk);
        drive(1'b0, W, MB + 32'h0, 32'h0, 32'd10, "cnt_lo_10");
        drive(1'b0, W, MB + 32'h4, 32'h0, 32'd0, "cnt_hi_0");
        chk("rst2_gpio", 64'(gpio_out), 64'd0);
        chk("rst2_err", 64'(err), 64'd0);
        drive(1'b0, W, 32'h10, 32'h0, 32'h0, "rst2_ram_cleared");
        dut.cnt_q = 64'h0000_0000_FFFF_FFFF;
        drive(1'b0, W, MB + 32'h0, 32'h0, 32'hFFFFFFFF, "cnt_lo_prewrap");
        drive(1'b0, W, MB + 32'h0, 32'h0, 32'h00000000, "cnt_lo_wrap");
        drive(1'b0, W, MB + 32'h4, 32'h0, 32'h00000001, "cnt_hi_carry");

        // Timer compare / irq
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
`ifdef DM_TIMER_EN
        drive(1'b1, W, MB + 32'h10, 32'd20, 32'h0, "cmp_wr_old");
        // Counter equals k at the k-th negedge after reset; match at cnt=20
        // lands on the next edge, so irq is visible from k=21.
        for (int k = 2; k <= 25; k++) begin
            @(negedge clk);
            #2;
            chk("irq_timing", 64'(irq), 64'(k >= 21));
        end
        drive(1'b0, W, MB + 32'h10, 32'h0, 32'd20, "cmp_rd");
        drive(1'b1, W, MB + 32'hC, 32'h4, 32'h4, "w1c_pend_old");
        chk("irq_cleared", 64'(irq), 64'd0);
        chk("irq_no_err", 64'(err), 64'd0);
`else
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            #2;
            chk("irq_tied_low", 64'(irq), 64'd0);
        end
        drive(1'b0, W, MB + 32'hC, 32'h0, 32'h0, "status_bit2_zero");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Reference cycle counter: edges since the last reset.
    logic [63:0] ref_cnt = '0;
    always @(posedge clk) begin
        if (reset) ref_cnt <= '0;
        else       ref_cnt <= ref_cnt + 64'd1;
    end

    function automatic logic [31:0] dut_cnt_model();
        return ref_cnt[31:0];
    endfunction
endmodule

// File: doc/dm_mmio.md
Name: dm_mmio

Overview:
Data-memory subsystem directly downstream of the pipeline CPU MEM stage. It consumes mem_w, DMType_out, Addr_out and Data_out, and returns Data_in in the same cycle.
- Contains a byte-lane RAM with sub-word load/store handling.
- Contains a small memory-mapped peripheral window: 64-bit cycle counter, GPIO output register and sticky access-error status.

Parameters:
DEPTH_WORDS, 128, RAM depth in 32-bit words; RAM occupies byte addresses 0 .. DEPTH_WORDS*4-1
MMIO_BASE, 32'h8000_0000, base byte address of the peripheral window (16 bytes)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
mem_w  input  1  store strobe from MEM stage
DMType  input  3  access type: 000 word, 001 half, 010 half-unsigned, 011 byte, 100 byte-unsigned
Addr  input  32  byte address
Din  input  32  store data; valid bits are right-aligned
Dout  output  32  load data, combinational, extended per DMType
gpio_out  output  16  GPIO output register
err  output  1  OR of the status sticky bits
irq  output  1  timer compare interrupt (see Optional Feature)

Behaviour:
- Reset (synchronous, reset=1 at the clock edge):
  - All RAM words, counter, gpio_out, status and compare registers are cleared to 0.
  - Dout reflects the cleared state. err=0, irq=0.
- Address decode:
  - RAM when Addr < DEPTH_WORDS*4.
  - MMIO when Addr[31:4] == MMIO_BASE[31:4].
  - Otherwise unmapped.
- Alignment:
  - Word accesses require Addr[1:0]==0.
  - Half accesses require Addr[0]==0.
  - Byte accesses are always aligned.
- RAM read (combinational):
  - Word: the full word.
  - Half: word[Addr[1]*16 +: 16], sign-extended (001) or zero-extended (010).
  - Byte: word[Addr[1:0]*8 +: 8], sign-extended (011) or zero-extended (100).
- RAM write (on clk edge when mem_w=1):
  - Only the addressed lanes are updated: byte writes Din[7:0]; half writes Din[15:0]; word writes all 4 lanes.
  - Other lanes are unchanged.
- Write/read timing:
  - Write latency is 1 cycle. A read of the same address in the cycle of the write returns the old data; the next cycle returns the new data.
- MMIO map (word offsets; MMIO accepts only word accesses):
  - +0x0: cycle counter low, read-only.
  - +0x4: cycle counter high, read-only.
  - +0x8: gpio_out, RW; write loads Din[15:0]; read returns the value zero-extended.
  - +0xC: status, RW1C; bit0 = misaligned, bit1 = unmapped/illegal; writing 1 clears the bit.
- Non-word MMIO access is an illegal access.
- Cycle counter:
  - 64-bit, increments by 1 every cycle while reset=0; wraps 2^64-1 → 0.
  - Reads return the live value; writes are ignored, with no error.
- Error handling:
  - Misaligned access: the write is suppressed, Dout=0, and status.bit0 is set on the edge if mem_w=1.
  - Misaligned reads: a read cannot be qualified, so it only returns 0 and does not set the bit.
  - Unmapped or illegal access: the write is ignored, Dout=0, and status.bit1 is set when mem_w=1.
- Simultaneous events: if the same edge sets a status bit and a W1C write targets status, set wins.
- Undefined DMType values (101–111) are treated as an illegal access.
- err = |status[1:0]. This is a registered path, so err asserts 1 cycle after the offending write.

Optional Feature:
Macro: DM_TIMER_EN
- Defined:
  - Adds a compare register at +0x10; the MMIO window grows to 32 bytes.
  - Writing the compare register loads Din and clears the pending bit. Reads return the value.
  - When counter[31:0] == compare and compare != 0, a pending bit is set on that edge.
  - irq = pending bit. Pending is also readable as status.bit2 and is W1C.
  - If the same edge both matches and W1C-clears pending, the set wins.
- Not defined:
  - Window is 16 bytes; +0x10 is unmapped and sets bit1 on write.
  - irq is tied to 0; status.bit2 reads 0.

Test Plan:
1. Reset, then word store 32'hDEADBEEF to 0x10, read 0x10 next cycle -> Dout=32'hDEADBEEF; same-cycle read before the edge returns 0.
2. After test 1, byte store 8'h5A to 0x12, then read 0x10 with DMType 000 -> 32'hDE5ABEEF; read 0x13 with DMType 011 -> 32'hFFFFFFDE; read 0x13 with DMType 100 -> 32'h000000DE; read 0x12 with DMType 001 -> 32'hFFFFDE5A.
3. Word store 32'h11111111 to 0x21 -> RAM unchanged, err=1 next cycle, status=1. Write 1 to MMIO_BASE+0xC -> status=0, err=0 next cycle.
4. Hold reset 1 cycle, release, wait 10 cycles, read MMIO_BASE+0x0 -> 10 (±0 against the counter reference model); preload is not possible, so force 2^32-1 via a hierarchical deposit and step 1 cycle -> low=0, high=1.
5. Word store 32'h0001ABCD to MMIO_BASE+0x8 -> gpio_out=16'hABCD next cycle. Byte store to MMIO_BASE+0x8 -> gpio_out unchanged, status.bit1=1. Store to 0x4000_0000 -> status.bit1=1, Dout=0.
6. With DM_TIMER_EN: write compare=20 right after reset -> irq=1 after the edge where counter=20. Write status=4 while irq is pending -> irq=0. Without the macro, irq stays 0 for 100 cycles.
